fifo_tx_serializer: RTL and testbench

- Downstream consumer of the team's synchronous FIFO.
- Pops one word whenever the FIFO is non-empty and the block is idle, then shifts it out as a framed serial stream: start bit, WL data bits LSB-first, stop bit.
- Sits between the FIFO read port and the off-block serial line; provides the FIFO's rReq.

---
 rtl/fifo_tx_serializer_pkg.sv | 25 ++
 rtl/fifo_tx_serializer_if.sv | 23 ++
 rtl/fifo_tx_serializer_baud_tick_gen.sv | 33 +++
 rtl/fifo_tx_serializer.sv | 116 +++++++++++
 tb/tb_fifo_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_tx_serializer_pkg.sv
// Shared state type, default line level and width helper for the FIFO-to-serial transmitter.
// The PARITY state is only reachable when FIFO_TX_PARITY_EN is defined.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

    // Equals $clog2(n)+1, so a count of 1 still yields a one-bit counter.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w + 1;
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_if.sv
// FIFO read side and serial output side of the transmitter, bundled for port connection.
// Unaffected by FIFO_TX_PARITY_EN.
interface fifo_tx_serializer_if #(
    parameter int WL = 3
) ();
    logic          en;
    logic          empty;
    logic          rReq;
    logic [WL-1:0] din;
    logic          sOut;
    logic          busy;
    logic          done;

    modport slave (
        input  en, empty, din,
        output rReq, sOut, busy, done
    );

    modport master (
        output en, empty, din,
        input  rReq, sOut, busy, done
    );
endinterface

// File: rtl/fifo_tx_serializer_baud_tick_gen.sv
// Bit-period counter: o_tick is high in the last clock of every CLKS_PER_BIT-cycle period.
// Unaffected by FIFO_TX_PARITY_EN.
module baud_tick_gen
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_restart,
    output logic o_tick,
    output logic o_tick_next
);
    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (i_restart || (r_cnt == LAST)) w_cnt_next = '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) r_cnt <= '0;
        else      r_cnt <= w_cnt_next;
    end

    // The look-ahead tick lets the parent register its done pulse.
    assign o_tick      = (r_cnt == LAST);
    assign o_tick_next = (w_cnt_next == LAST);
endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from a synchronous FIFO and sends each as start, WL data bits LSB-first, stop.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int   WL           = 3,
    parameter int   CLKS_PER_BIT = 4,
    parameter logic IDLE_LEVEL   = DEFAULT_IDLE_LEVEL
) (
    input logic                 CLK,
    input logic                 RST,
    fifo_tx_serializer_if.slave bus
);
    localparam int            BW       = cnt_width(WL);
    localparam logic [BW-1:0] LAST_BIT = BW'(WL - 1);

    tx_state_t     r_state, w_state_next;
    logic [WL-1:0] r_shreg, w_shreg_next;
    logic [BW-1:0] r_bitcnt, w_bitcnt_next;
    logic          r_sout, w_sout_next;
    logic          r_busy, r_done;
    logic          w_tick, w_tick_next, w_restart, w_rreq;
`ifdef FIFO_TX_PARITY_EN
    logic          r_parity;
`endif

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK         (CLK),
        .RST         (RST),
        .i_restart   (w_restart),
        .o_tick      (w_tick),
        .o_tick_next (w_tick_next)
    );

    always_comb begin
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_bitcnt_next = r_bitcnt;
        w_restart     = 1'b0;
        w_rreq        = 1'b0;
        case (r_state)
            IDLE: if (bus.en && !bus.empty) w_state_next = REQ;
            // Re-checking empty here guarantees the FIFO is never read while empty.
            REQ: begin
                w_rreq       = !bus.empty;
                w_state_next = bus.empty ? IDLE : LOAD;
            end
            LOAD: begin
                w_shreg_next  = bus.din;
                w_bitcnt_next = '0;
                w_restart     = 1'b1;
                w_state_next  = START;
            end
            START: if (w_tick) w_state_next = DATA;
            DATA: if (w_tick) begin
                w_shreg_next  = r_shreg >> 1;
                w_bitcnt_next = r_bitcnt + 1'b1;
                if (r_bitcnt == LAST_BIT) begin
`ifdef FIFO_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: if (w_tick) w_state_next = STOP;
`endif
            STOP: if (w_tick) w_state_next = (bus.en && !bus.empty) ? REQ : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Line level is decided from the next state so the pin comes straight off a flop.
    always_comb begin
        w_sout_next = IDLE_LEVEL;
        case (w_state_next)
            START:  w_sout_next = ~IDLE_LEVEL;
            DATA:   w_sout_next = w_shreg_next[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY: w_sout_next = r_parity;
`endif
            default: w_sout_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_sout   <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_bitcnt <= w_bitcnt_next;
            r_sout   <= w_sout_next;
            r_busy   <= (w_state_next != IDLE);
            r_done   <= (w_state_next == STOP) && w_tick_next;
        end
    end

`ifdef FIFO_TX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RST)                 r_parity <= 1'b0;
        else if (r_state == LOAD) r_parity <= ^bus.din;
    end
`endif

    assign bus.rReq = w_rreq;
    assign bus.sOut = r_sout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Self-checking bench for fifo_tx_serializer (WL=3, CLKS_PER_BIT=2) with a queue-based FIFO model.
// Expected frames follow FIFO_TX_PARITY_EN when the bench is built with that macro.
module tb_fifo_tx_serializer;
    localparam int WL  = 3;
    localparam int CPB = 2;
`ifdef FIFO_TX_PARITY_EN
    localparam int NBITS = WL + 3;
`else
    localparam int NBITS = WL + 2;
`endif
    localparam int BUSY_LEN = 2 + NBITS * CPB;

    typedef struct packed {
        logic rreq;
        logic busy;
        logic sout;
        logic done;
    } out_t;

    typedef struct {
        logic [WL-1:0] word;
        logic [15:0]   exp_sout;
    } vec_t;

    localparam out_t IDLE_OUT = '{rreq: 1'b0, busy: 1'b0, sout: 1'b1, done: 1'b0};

    logic CLK = 1'b0;
    logic RST;
    fifo_tx_serializer_if #(.WL(WL)) bus ();

    fifo_tx_serializer #(.WL(WL), .CLKS_PER_BIT(CPB), .IDLE_LEVEL(1'b1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            fifo_err = 0;
    int            tot_rreq = 0;
    int            tot_busy = 0;
    logic [WL-1:0] fifo_q[$];
    out_t          pend[$];
    out_t          exp_now, got_now;
    logic          force_empty = 1'b0;
    logic          rreq_s;
    vec_t          vecs[5];
    logic [15:0]   seq_sout, seq_rreq, seq_done;
    int            blen, guard, k, r0, b0;
    logic          started;
    logic          rnd_rst, rnd_en, rnd_push;
    logic [WL-1:0] rnd_word;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Whole frame as the line should show it: REQ, LOAD, then each bit held CPB cycles.
    function automatic void gen_frame(input logic [WL-1:0] w);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < WL; i++) bits.push_back(w[i]);
`ifdef FIFO_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        pend.push_back('{rreq: 1'b1, busy: 1'b1, sout: 1'b1, done: 1'b0});
        pend.push_back('{rreq: 1'b0, busy: 1'b1, sout: 1'b1, done: 1'b0});
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < CPB; c++)
                pend.push_back('{rreq: 1'b0, busy: 1'b1, sout: bits[b],
                                 done: (b == bits.size() - 1) && (c == CPB - 1)});
    endfunction

    task automatic model_edge(input logic rst_s, input logic en_s, input logic empty_s);
        if (!rst_s) begin
            pend.delete();
            exp_now = IDLE_OUT;
        end else begin
            if (pend.size() == 0 && en_s && !empty_s && fifo_q.size() > 0) gen_frame(fifo_q[0]);
            if (pend.size() > 0) exp_now = pend.pop_front();
            else                 exp_now = IDLE_OUT;
        end
    endtask

    // One clock: service the FIFO, drive inputs for the next edge, compare against the model.
    task automatic step(input logic rst_d, input logic en_d, input logic push_d, input logic [WL-1:0] push_w);
        logic rs, es, ms;
        @(negedge CLK);
        rreq_s = bus.rReq;
        if (rreq_s === 1'b1 && bus.empty !== 1'b0) fifo_err++;
        @(posedge CLK);
        #1;
        cyc++;
        rs = RST;
        es = bus.en;
        ms = bus.empty;
        if (rreq_s === 1'b1 && fifo_q.size() > 0) bus.din = fifo_q.pop_front();
        if (push_d) fifo_q.push_back(push_w);
        RST       = rst_d;
        bus.en    = en_d;
        bus.empty = force_empty || (fifo_q.size() == 0);
        #1;
        model_edge(rs, es, ms);
        got_now = '{rreq: bus.rReq, busy: bus.busy, sout: bus.sOut, done: bus.done};
        check("cycle_outputs", 32'(got_now), 32'(exp_now));
        if (bus.rReq === 1'b1) tot_rreq++;
        if (bus.busy === 1'b1) tot_busy++;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < bound) begin
            step(1'b1, bus.en, 1'b0, '0);
            n++;
        end
        check("idle_within_bound", 32'(n < bound), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FIFO_TX_PARITY_EN
        vecs[0] = '{3'd5, 16'b0011001100110011};
        vecs[1] = '{3'd2, 16'b0011000011001111};
        vecs[2] = '{3'd7, 16'b0011001111111111};
        vecs[3] = '{3'd4, 16'b0011000000111111};
        vecs[4] = '{3'd0, 16'b0011000000000011};
`else
        vecs[0] = '{3'd5, 16'b0000110011001111};
        vecs[1] = '{3'd2, 16'b0000110000110011};
        vecs[2] = '{3'd7, 16'b0000110011111111};
        vecs[3] = '{3'd4, 16'b0000110000001111};
        vecs[4] = '{3'd0, 16'b0000110000000011};
`endif
        RST       = 1'b0;
        bus.en    = 1'b1;
        bus.din   = '0;
        fifo_q.push_back(3'd6);
        bus.empty = 1'b0;

        // Reset held two edges with work pending: line stays idle.
        for (int i = 0; i < 2; i++) begin
            step(i == 1, 1'b1, 1'b0, '0);
            check("reset_sout", 32'(bus.sOut), 32'd1);
            check("reset_rreq", 32'(bus.rReq), 32'd0);
            check("reset_busy", 32'(bus.busy), 32'd0);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        check("first_rreq_after_release", 32'(bus.rReq), 32'd1);
        wait_idle(40);

        // Single-word frames from the vector table.
        for (int v = 0; v < 5; v++) begin
            step(1'b1, 1'b1, 1'b1, vecs[v].word);
            seq_sout = '0; seq_rreq = '0; seq_done = '0;
            blen = 0; guard = 0; started = 1'b0;
            while (guard < 40) begin
                step(1'b1, 1'b1, 1'b0, '0);
                guard++;
                if (bus.busy === 1'b1) begin
                    started  = 1'b1;
                    seq_sout = {seq_sout[14:0], bus.sOut};
                    seq_rreq = {seq_rreq[14:0], bus.rReq};
                    seq_done = {seq_done[14:0], bus.done};
                    blen++;
                end else if (started) begin
                    break;
                end
            end
            check("table_busy_len", 32'(blen), 32'(BUSY_LEN));
            check("table_sout_seq", 32'(seq_sout), 32'(vecs[v].exp_sout));
            check("table_rreq_seq", 32'(seq_rreq), 32'(16'(1) << (BUSY_LEN - 1)));
            check("table_done_seq", 32'(seq_done), 32'd1);
            $display("frame word=%0d busy_cycles=%0d line=%b", vecs[v].word, blen, seq_sout);
        end

        // Back-to-back frames: 2,5,7,4 with no idle gap.
        r0 = tot_rreq; b0 = tot_busy;
        step(1'b1, 1'b1, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 3'd5);
        step(1'b1, 1'b1, 1'b1, 3'd7);
        step(1'b1, 1'b1, 1'b1, 3'd4);
        guard = 0;
        while (bus.busy === 1'b1 && guard < 100) begin
            step(1'b1, 1'b1, 1'b0, '0);
            guard++;
        end
        check("b2b_rreq_count", 32'(tot_rreq - r0), 32'd4);
        check("b2b_busy_span", 32'(tot_busy - b0), 32'(4 * BUSY_LEN));
        check("b2b_fifo_error", 32'(fifo_err), 32'd0);
        $display("back-to-back: rreq=%0d busy_cycles=%0d", tot_rreq - r0, tot_busy - b0);

        // Forced empty, then en low: no reads.
        force_empty = 1'b1;
        r0 = tot_rreq; b0 = tot_busy;
        step(1'b1, 1'b1, 1'b1, 3'd3);
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);
        check("empty_gate_rreq", 32'(tot_rreq - r0), 32'd0);
        check("empty_gate_busy", 32'(tot_busy - b0), 32'd0);
        force_empty = 1'b0;
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (10) step(1'b1, 1'b0, 1'b0, '0);
        check("en_gate_rreq", 32'(tot_rreq - r0), 32'd0);
        check("en_gate_fifo_level", 32'(fifo_q.size()), 32'd1);

        // en dropped mid-frame: frame completes, second word stays queued.
        step(1'b1, 1'b0, 1'b1, 3'd6);
        b0 = tot_busy;
        step(1'b1, 1'b1, 1'b0, '0);
        repeat (4) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        wait_idle(40);
        r0 = tot_rreq;
        repeat (10) step(1'b1, 1'b0, 1'b0, '0);
        check("en_drop_frame_len", 32'(tot_busy - b0), 32'(BUSY_LEN));
        check("en_drop_no_new_rreq", 32'(tot_rreq - r0), 32'd0);
        check("en_drop_fifo_level", 32'(fifo_q.size()), 32'd1);
        $display("en drop: busy_cycles=%0d queued=%0d", tot_busy - b0, fifo_q.size());
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        wait_idle(40);

        // Reset during DATA bit 1 aborts the frame; next word goes only after release.
        step(1'b1, 1'b1, 1'b1, 3'd5);
        step(1'b1, 1'b1, 1'b1, 3'd4);
        k = (bus.busy === 1'b1) ? 1 : 0;
        guard = 0;
        while (k < 7 && guard < 30) begin
            step(1'b1, 1'b1, 1'b0, '0);
            guard++;
            if (bus.busy === 1'b1) k++;
        end
        check("midreset_reached_bit1", 32'(k), 32'd7);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("midreset_sout", 32'(bus.sOut), 32'd1);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("midreset_hold_rreq", 32'(bus.rReq), 32'd0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("midreset_restart_rreq", 32'(bus.rReq), 32'd1);
        wait_idle(40);
        $display("mid-frame reset: queued after restart=%0d", fifo_q.size());

        // Random traffic against the frame model.
        for (int i = 0; i < 800; i++) begin
            rnd_rst  = ($urandom_range(0, 299) != 0);
            rnd_en   = ($urandom_range(0, 7) != 0);
            rnd_push = ($urandom_range(0, 5) == 0) && (fifo_q.size() < 6);
            rnd_word = WL'($urandom_range(0, 7));
            step(rnd_rst, rnd_en, rnd_push, rnd_word);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        guard = 0;
        while ((fifo_q.size() > 0 || bus.busy === 1'b1) && guard < 400) begin
            step(1'b1, 1'b1, 1'b0, '0);
            guard++;
        end
        check("random_drained", 32'(fifo_q.size()), 32'd0);
        check("random_fifo_error", 32'(fifo_err), 32'd0);
        $display("random phase: cycles=%0d reads=%0d", cyc, tot_rreq);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
